pcpi_nibble_bridge: RTL and testbench
=====================================

Name: pcpi_nibble_bridge

Overview:
- Sits between the chip pins and the PCPI coprocessor (fused matrix-multiply unit).
- Deserialises a 32-bit instruction from eight 4-bit pin segments and issues it on the PCPI request handshake.
- Captures the coprocessor result and serialises it back out as eight 4-bit nibbles under a result handshake.
- Replaces the ad-hoc level-sensitive loader; adds edge-qualified strobes, a PCPI timeout and a result path.

Parameters:
- TIMEOUT, 64: cycles without pcpi_ready (and pcpi_wait low) before the request is aborted; must be ≥2.
- TO_W, 7: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_valid  in  1  segment strobe from pins; its rising edge (0→1) marks a new nibble.
- seg_data  in  4  instruction nibble, sampled on the seg_valid rising-edge cycle.
- seg_ack  out  1  one-cycle pulse, the cycle after a nibble is accepted.
- pcpi_valid  out  1  PCPI request.
- pcpi_insn  out  32  assembled instruction, registered.
- pcpi_ready  in  1  coprocessor completion.
- pcpi_wr  in  1  coprocessor has a result to write back; qualified by pcpi_ready.
- pcpi_rd  in  32  coprocessor result; qualified by pcpi_ready && pcpi_wr.
- pcpi_wait  in  1  coprocessor busy; freezes the timeout counter.
- res_valid  out  1  result nibble available.
- res_nibble  out  4  current result nibble.
- res_ack  in  1  consumer took res_nibble; qualified by res_valid.
- done  out  1  one-cycle pulse at transaction end (success or timeout).
- err  out  1  sticky timeout flag.
- busy  out  1  high in ISSUE or SEND, or in LOAD when nib_cnt≠0.

Behaviour:
- Reset (rst=1 at a clock edge): state=LOAD; nib_cnt=0; snd_cnt=0; to_cnt=0; seg_prev=0.
- Reset forces every output low; pcpi_insn=0, res_nibble=0, result register=0.
- Reset aborts any operation in progress; pcpi_valid is low from the next cycle.
- Edge detect: seg_prev is a register of seg_valid. acc = seg_valid && !seg_prev && state==LOAD.
- seg_prev is updated in all states, so a strobe held high across the end of a transaction is not re-accepted.
- LOAD: on acc, write pcpi_insn[4*nib_cnt +: 4] <= seg_data (LSB nibble first), nib_cnt++, seg_ack=1 next cycle.
- LOAD: the acc that takes nib_cnt from 7 to 0 also sets pcpi_valid<=1, to_cnt<=0 and state<=ISSUE, so pcpi_valid rises 1 cycle after the 8th strobe edge.
- LOAD: the first acc of a transaction (nib_cnt==0) clears err.
- ISSUE: pcpi_valid held high and pcpi_insn stable until exit.
- ISSUE, pcpi_ready=1: pcpi_valid<=0.
  - If pcpi_wr=1: result<=pcpi_rd, snd_cnt<=0, state<=SEND.
  - If pcpi_wr=0: done<=1, state<=LOAD.
- ISSUE, pcpi_ready=0 and pcpi_wait=0: to_cnt++.
- ISSUE, pcpi_ready=0 and pcpi_wait=1: to_cnt held.
- ISSUE timeout: when to_cnt==TIMEOUT-1 and an increment is due: pcpi_valid<=0, err<=1, done<=1, state<=LOAD.
- ISSUE: pcpi_ready beats the timeout if both occur in the same cycle.
- SEND: res_valid=1; res_nibble=result[4*snd_cnt +: 4], combinational from registers.
- SEND, on res_ack: snd_cnt++. If snd_cnt was 7: res_valid<=0, done<=1, state<=LOAD.
- SEND: res_ack while res_valid=0 is ignored.
- Strobes in ISSUE or SEND are dropped: no seg_ack, no nib_cnt change.
- seg_data is never sampled without a rising edge; a strobe held high loads exactly one nibble.
- Counters wrap at 3 bits by design. nib_cnt and snd_cnt are always 0 when the block is in LOAD with no partial load pending.

Test Plan:
- Load nibbles B,0,0,5,0,0,2,0 with 1-cycle strobes separated by ≥1 low cycle -> pcpi_insn=0x0200500B; pcpi_valid rises 1 cycle after the 8th edge; 8 seg_ack pulses; busy=1 from the first ack.
- From ISSUE, pcpi_ready=1, pcpi_wr=1, pcpi_rd=0xDEADBEEF after 5 cycles -> pcpi_valid drops; res_nibble sequence F,E,E,B,D,A,E,D with res_ack every cycle; done pulses once after the 8th ack; res_valid=0.
- pcpi_ready=1 with pcpi_wr=0 -> no res_valid; done pulse next cycle; next load starts at nib_cnt=0.
- TIMEOUT=64, no ready, pcpi_wait=1 for 20 cycles, then 0 -> abort exactly 84 cycles after ISSUE entry; err=1; done pulse; the next first nibble clears err.
- seg_valid held high 10 cycles during LOAD, and strobes pulsed during ISSUE -> exactly one nibble accepted in LOAD; none accepted in ISSUE; pcpi_insn unchanged while pcpi_valid=1.
- rst asserted mid-SEND after 3 acks, and separately after 4 nibbles -> all outputs 0 next cycle; a fresh 8-nibble load issues a correct instruction.

Source files
------------

// File: rtl/pcpi_nibble_bridge_if.sv
// Pin-side nibble strobes, PCPI request/response and result handshake signals
// grouped for the pcpi_nibble_bridge.
interface pcpi_nibble_bridge_if;
  logic        seg_valid;
  logic [3:0]  seg_data;
  logic        seg_ack;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        res_valid;
  logic [3:0]  res_nibble;
  logic        res_ack;
  logic        done;
  logic        err;
  logic        busy;

  modport master (
    input  seg_valid, seg_data, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, res_ack,
    output seg_ack, pcpi_valid, pcpi_insn, res_valid, res_nibble, done, err, busy
  );

  modport slave (
    output seg_valid, seg_data, pcpi_ready, pcpi_wr, pcpi_rd, pcpi_wait, res_ack,
    input  seg_ack, pcpi_valid, pcpi_insn, res_valid, res_nibble, done, err, busy
  );
endinterface

// File: rtl/pcpi_nibble_bridge.sv
// Assembles a 32-bit PCPI instruction from eight edge-qualified pin nibbles,
// issues it with a timeout, and streams the coprocessor result back out as nibbles.
module pcpi_nibble_bridge #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic                  clk,
  input logic                  rst,
  pcpi_nibble_bridge_if.master bus
);
  typedef enum logic [1:0] {LOAD, ISSUE, SEND} state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [2:0]      nib_cnt_q, nib_cnt_d;
  logic [2:0]      snd_cnt_q, snd_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            seg_prev_q, seg_prev_d;
  logic            seg_ack_q, seg_ack_d;
  logic            pcpi_valid_q, pcpi_valid_d;
  logic [31:0]     insn_q, insn_d;
  logic [31:0]     result_q, result_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            acc;
  logic            in_send;

  // Only a 0->1 transition of the strobe while loading counts as a new nibble.
  assign acc     = bus.seg_valid && !seg_prev_q && (state_q == LOAD);
  assign in_send = (state_q == SEND);

  always_comb begin
    state_d      = state_q;
    nib_cnt_d    = nib_cnt_q;
    snd_cnt_d    = snd_cnt_q;
    to_cnt_d     = to_cnt_q;
    seg_prev_d   = bus.seg_valid;
    seg_ack_d    = 1'b0;
    pcpi_valid_d = pcpi_valid_q;
    insn_d       = insn_q;
    result_d     = result_q;
    done_d       = 1'b0;
    err_d        = err_q;
    case (state_q)
      LOAD: begin
        if (acc) begin
          insn_d[{nib_cnt_q, 2'b00} +: 4] = bus.seg_data;
          nib_cnt_d = nib_cnt_q + 3'd1;
          seg_ack_d = 1'b1;
          if (nib_cnt_q == 3'd0) err_d = 1'b0;
          if (nib_cnt_q == 3'd7) begin
            pcpi_valid_d = 1'b1;
            to_cnt_d     = '0;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.pcpi_ready) begin
          pcpi_valid_d = 1'b0;
          if (bus.pcpi_wr) begin
            result_d  = bus.pcpi_rd;
            snd_cnt_d = 3'd0;
            state_d   = SEND;
          end else begin
            done_d  = 1'b1;
            state_d = LOAD;
          end
        end else if (!bus.pcpi_wait) begin
          // The increment that would reach TIMEOUT aborts instead.
          if (to_cnt_q == TO_LAST) begin
            pcpi_valid_d = 1'b0;
            err_d        = 1'b1;
            done_d       = 1'b1;
            state_d      = LOAD;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
      SEND: begin
        if (bus.res_ack) begin
          snd_cnt_d = snd_cnt_q + 3'd1;
          if (snd_cnt_q == 3'd7) begin
            done_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      nib_cnt_q    <= 3'd0;
      snd_cnt_q    <= 3'd0;
      to_cnt_q     <= '0;
      seg_prev_q   <= 1'b0;
      seg_ack_q    <= 1'b0;
      pcpi_valid_q <= 1'b0;
      insn_q       <= 32'd0;
      result_q     <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nib_cnt_q    <= nib_cnt_d;
      snd_cnt_q    <= snd_cnt_d;
      to_cnt_q     <= to_cnt_d;
      seg_prev_q   <= seg_prev_d;
      seg_ack_q    <= seg_ack_d;
      pcpi_valid_q <= pcpi_valid_d;
      insn_q       <= insn_d;
      result_q     <= result_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign bus.seg_ack    = seg_ack_q;
  assign bus.pcpi_valid = pcpi_valid_q;
  assign bus.pcpi_insn  = insn_q;
  assign bus.res_valid  = in_send;
  assign bus.res_nibble = in_send ? result_q[{snd_cnt_q, 2'b00} +: 4] : 4'd0;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.busy       = (state_q != LOAD) || (nib_cnt_q != 3'd0);
endmodule

// File: tb/tb_pcpi_nibble_bridge.sv
// Directed bench for pcpi_nibble_bridge: a queue-based transaction model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_pcpi_nibble_bridge;
  localparam int TIMEOUT = 64;
  localparam int PH_LOAD = 0, PH_ISSUE = 1, PH_SEND = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcpi_nibble_bridge_if bus();

  pcpi_nibble_bridge #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int total = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction model: nibbles collected in a queue, result nibbles drained from a queue.
  int          ph = PH_LOAD;
  logic [3:0]  loaded[$];
  logic [3:0]  out_q[$];
  logic [31:0] m_insn = 32'd0;
  logic [31:0] m_rd;
  bit          m_err = 0, m_ack = 0, m_done = 0, m_prev = 0, m_edge;
  int          waited = 0;
  int          ack_cnt = 0, done_cnt = 0;

  always @(posedge clk) begin
    if (bus.seg_ack === 1'b1) ack_cnt++;
    if (bus.done === 1'b1) done_cnt++;
    if (rst) begin
      ph = PH_LOAD; loaded.delete(); out_q.delete();
      m_insn = 32'd0; m_err = 0; m_ack = 0; m_done = 0; m_prev = 0; waited = 0;
    end else begin
      m_ack = 0; m_done = 0;
      m_edge = bus.seg_valid && !m_prev;
      m_prev = bus.seg_valid;
      if (ph == PH_LOAD) begin
        if (m_edge) begin
          if (loaded.size() == 0) m_err = 0;
          m_insn[4*loaded.size() +: 4] = bus.seg_data;
          loaded.push_back(bus.seg_data);
          m_ack = 1;
          if (loaded.size() == 8) begin
            loaded.delete(); ph = PH_ISSUE; waited = 0;
          end
        end
      end else if (ph == PH_ISSUE) begin
        if (bus.pcpi_ready) begin
          if (bus.pcpi_wr) begin
            m_rd = bus.pcpi_rd;
            for (int i = 0; i < 8; i++) out_q.push_back(m_rd[4*i +: 4]);
            ph = PH_SEND;
          end else begin
            m_done = 1; ph = PH_LOAD;
          end
        end else if (!bus.pcpi_wait) begin
          waited++;
          if (waited == TIMEOUT) begin
            m_err = 1; m_done = 1; ph = PH_LOAD;
          end
        end
      end else begin
        if (bus.res_ack) begin
          void'(out_q.pop_front());
          if (out_q.size() == 0) begin
            m_done = 1; ph = PH_LOAD;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg_ack", bus.seg_ack, m_ack);
      chk("pcpi_valid", bus.pcpi_valid, ph == PH_ISSUE);
      chk("pcpi_insn", bus.pcpi_insn, m_insn);
      chk("res_valid", bus.res_valid, ph == PH_SEND);
      chk("res_nibble", bus.res_nibble, (ph == PH_SEND) ? out_q[0] : 4'd0);
      chk("done", bus.done, m_done);
      chk("err", bus.err, m_err);
      chk("busy", bus.busy, (ph != PH_LOAD) || (loaded.size() != 0));
    end
  end

  task automatic send_nib(input logic [3:0] n);
    bus.seg_data = n; bus.seg_valid = 1'b1;
    @(negedge clk);
    bus.seg_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_nib(w[4*i +: 4]);
  endtask

  task automatic respond(input logic wr, input logic [31:0] rd);
    bus.pcpi_ready = 1'b1; bus.pcpi_wr = wr; bus.pcpi_rd = rd;
    @(negedge clk);
    bus.pcpi_ready = 1'b0; bus.pcpi_wr = 1'b0;
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_pcpi_valid"}, bus.pcpi_valid, 0);
    chk({tag, "_insn"}, bus.pcpi_insn, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_nibble"}, bus.res_nibble, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_seg_ack"}, bus.seg_ack, 0);
  endtask

  logic [3:0] exp_seq [8] = '{4'hF, 4'hE, 4'hE, 4'hB, 4'hD, 4'hA, 4'hE, 4'hD};
  logic [3:0] got_seq [8];
  int a0, d0, k;

  initial begin
    rst = 1'b1;
    bus.seg_valid = 0; bus.seg_data = 0; bus.pcpi_ready = 0; bus.pcpi_wr = 0;
    bus.pcpi_rd = 0; bus.pcpi_wait = 0; bus.res_ack = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check_all_low("reset");
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic load of 0x0200500B, then result 0xDEADBEEF streamed back.
    a0 = ack_cnt;
    send_nib(4'hB);
    chk("busy_after_first", bus.busy, 1);
    send_nib(4'h0); send_nib(4'h0); send_nib(4'h5);
    send_nib(4'h0); send_nib(4'h0); send_nib(4'h2); send_nib(4'h0);
    chk("load_insn", bus.pcpi_insn, 32'h0200500B);
    chk("load_valid", bus.pcpi_valid, 1);
    chk("load_acks", ack_cnt - a0, 8);
    repeat (4) @(negedge clk);
    d0 = done_cnt;
    respond(1'b1, 32'hDEADBEEF);
    bus.res_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got_seq[i] = bus.res_nibble;
      @(negedge clk);
    end
    bus.res_ack = 1'b0;
    chk("send_done_pulse", bus.done, 1);
    chk("send_res_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("send_done_count", done_cnt - d0, 1);
    for (int i = 0; i < 8; i++) chk("send_nibble_seq", got_seq[i], exp_seq[i]);

    // Completion without write-back.
    load_word(32'h12345678);
    chk("nowr_insn", bus.pcpi_insn, 32'h12345678);
    d0 = done_cnt;
    respond(1'b0, 32'hFFFFFFFF);
    chk("nowr_done", bus.done, 1);
    chk("nowr_res_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("nowr_done_count", done_cnt - d0, 1);
    load_word(32'hA5A50F0F);
    chk("nowr_next_insn", bus.pcpi_insn, 32'hA5A50F0F);
    respond(1'b0, 32'h0);
    @(negedge clk);

    // Timeout with 20 wait cycles: abort 84 cycles after ISSUE entry.
    bus.pcpi_wait = 1'b1;
    load_word(32'h0BADF00D);
    d0 = done_cnt;
    k = 2;
    while (bus.pcpi_valid === 1'b1 && k < 300) begin
      if (k == 21) bus.pcpi_wait = 1'b0;
      @(negedge clk);
      k++;
    end
    bus.pcpi_wait = 1'b0;
    chk("timeout_cycles", k - 1, 84);
    chk("timeout_err", bus.err, 1);
    chk("timeout_done", bus.done, 1);
    send_nib(4'h1);
    chk("timeout_err_cleared", bus.err, 0);
    chk("timeout_done_count", done_cnt - d0, 1);
    for (int i = 1; i < 8; i++) send_nib(4'h0);
    respond(1'b0, 32'h0);
    @(negedge clk);

    // Held strobe loads one nibble; strobes during ISSUE are dropped.
    a0 = ack_cnt;
    bus.seg_data = 4'h3; bus.seg_valid = 1'b1;
    @(negedge clk);
    bus.seg_data = 4'h9;
    repeat (9) @(negedge clk);
    bus.seg_valid = 1'b0;
    @(negedge clk);
    chk("held_acks", ack_cnt - a0, 1);
    for (int i = 1; i < 8; i++) send_nib(4'(i));
    chk("held_insn", bus.pcpi_insn, 32'h76543213);
    a0 = ack_cnt;
    send_nib(4'hF); send_nib(4'hE); send_nib(4'hD);
    chk("issue_drop_acks", ack_cnt - a0, 0);
    chk("issue_insn_stable", bus.pcpi_insn, 32'h76543213);
    chk("issue_valid_held", bus.pcpi_valid, 1);
    respond(1'b0, 32'h0);
    @(negedge clk);

    // Reset in the middle of SEND after three acks.
    load_word(32'h11112222);
    respond(1'b1, 32'h13579BDF);
    bus.res_ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.res_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_all_low("rst_send");
    rst = 1'b0;

    // Reset after four nibbles, then a fresh full load.
    send_nib(4'h4); send_nib(4'h3); send_nib(4'h2); send_nib(4'h1);
    rst = 1'b1;
    @(negedge clk);
    check_all_low("rst_load");
    rst = 1'b0;
    load_word(32'hCAFEF00D);
    chk("fresh_insn", bus.pcpi_insn, 32'hCAFEF00D);
    chk("fresh_valid", bus.pcpi_valid, 1);
    respond(1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
